// File: rtl/mode_seq.sv
// Mode sequencer: commands a worker block, accumulates LEN result beats per
// transaction and reports completion with a one-cycle pulse.
package mytypes;
  typedef enum logic {start, done} mode_t;
endpackage

module mode_seq
  import mytypes::mode_t;
  import mytypes::start;
  import mytypes::done;
#(
  parameter int unsigned LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        abort,
  output mode_t       mode,
  input  logic [7:0]  data_in,
  input  logic        data_vld,
  output logic        busy,
  output logic [15:0] sum,
  output logic [7:0]  cnt,
  output logic        result_valid
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = 16;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = cnt + CNT_W'(1);

  // State and all outputs advance together so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      mode         <= done;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      sum          <= '0;
      cnt          <= '0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_state <= RUN;
            mode    <= start;
            busy    <= 1'b1;
            sum     <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          // Abort wins over a same-cycle beat; partial totals stay visible.
          if (abort) begin
            r_state <= IDLE;
            mode    <= done;
            busy    <= 1'b0;
          end else if (data_vld) begin
            sum <= sum + SUM_W'(data_in);
            cnt <= w_cnt_inc;
            if (w_cnt_inc == LEN_C) begin
              r_state      <= REPORT;
              mode         <= done;
              result_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          mode    <= done;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_seq.sv
// Bench for mode_seq: LEN=4, LEN=255 and LEN=1 instances checked against
// transaction-level expectations computed from beat lists.
module tb_mode_seq;
  import mytypes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_go, a_abort, a_vld, a_busy, a_rv;
  logic [7:0]  a_din, a_cnt;
  logic [15:0] a_sum;
  mode_t       a_mode;

  logic        b_go, b_abort, b_vld, b_busy, b_rv;
  logic [7:0]  b_din, b_cnt;
  logic [15:0] b_sum;
  mode_t       b_mode;

  logic        c_go, c_abort, c_vld, c_busy, c_rv;
  logic [7:0]  c_din, c_cnt;
  logic [15:0] c_sum;
  mode_t       c_mode;

  mode_seq #(.LEN(4)) u_a (
    .clk(clk), .rst(rst), .go(a_go), .abort(a_abort), .mode(a_mode),
    .data_in(a_din), .data_vld(a_vld), .busy(a_busy), .sum(a_sum),
    .cnt(a_cnt), .result_valid(a_rv)
  );

  mode_seq #(.LEN(255)) u_b (
    .clk(clk), .rst(rst), .go(b_go), .abort(b_abort), .mode(b_mode),
    .data_in(b_din), .data_vld(b_vld), .busy(b_busy), .sum(b_sum),
    .cnt(b_cnt), .result_valid(b_rv)
  );

  mode_seq #(.LEN(1)) u_c (
    .clk(clk), .rst(rst), .go(c_go), .abort(c_abort), .mode(c_mode),
    .data_in(c_din), .data_vld(c_vld), .busy(c_busy), .sum(c_sum),
    .cnt(c_cnt), .result_valid(c_rv)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Observations gathered while driving a LEN=4 transaction
  int o_cyc, o_rv_cnt, o_rv_cyc, o_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_tick();
    tick();
    o_cyc++;
    if (a_rv) begin
      o_rv_cnt++;
      o_rv_cyc = o_cyc;
    end
    if (a_mode == start) o_start++;
  endtask

  // Drives one LEN=4 transaction; abort_idx < 0 means no abort.
  task automatic drive_txn(input logic [7:0] beats[4], input int gaps[4],
                           input int abort_idx, input logic [7:0] abort_din,
                           input bit noise);
    o_cyc = 0; o_rv_cnt = 0; o_rv_cyc = -1; o_start = 0;
    a_go = 1'b1;
    a_tick();
    a_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == abort_idx) begin
        a_abort = 1'b1; a_vld = 1'b1; a_din = abort_din;
        a_go = noise ? 1'($urandom % 2) : 1'b0;
        a_tick();
        a_abort = 1'b0; a_vld = 1'b0; a_go = 1'b0;
        break;
      end
      a_vld = 1'b1; a_din = beats[i];
      a_go = (noise && i < 3) ? 1'($urandom % 2) : 1'b0;
      a_tick();
      a_vld = 1'b0; a_go = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gaps[i]; g++) begin
          a_go = noise ? 1'($urandom % 2) : 1'b0;
          a_din = 8'($urandom);
          a_tick();
          a_go = 1'b0;
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      a_vld = noise ? 1'($urandom % 2) : 1'b0;
      a_din = 8'($urandom);
      a_tick();
      a_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_go = 1'b1; a_vld = 1'b1; a_abort = 1'b0; a_din = 8'hAA;
    b_go = 1'b0; b_vld = 1'b0; b_abort = 1'b0; b_din = 8'h00;
    c_go = 1'b0; c_vld = 1'b0; c_abort = 1'b0; c_din = 8'h00;
    tick(); tick(); tick();
    n_total++; if (a_mode !== done) $display("FAIL reset_mode: got %0d exp %0d", a_mode, done); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", a_busy); else n_pass++;
    n_total++; if (a_rv !== 1'b0) $display("FAIL reset_rv: got %b exp 0", a_rv); else n_pass++;
    n_total++; if (a_sum !== 16'h0) $display("FAIL reset_sum: got %h exp 0000", a_sum); else n_pass++;
    n_total++; if (a_cnt !== 8'h0) $display("FAIL reset_cnt: got %h exp 00", a_cnt); else n_pass++;
    n_total++; if (b_busy !== 1'b0 || b_sum !== 16'h0) $display("FAIL reset_b: busy %b sum %h exp 0 0000", b_busy, b_sum); else n_pass++;
    n_total++; if (c_mode !== done || c_cnt !== 8'h0) $display("FAIL reset_c: mode %0d cnt %h exp %0d 00", c_mode, c_cnt, done); else n_pass++;
    a_go = 1'b0; a_vld = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] beats[4];
    int gaps[4];
    beats = '{8'h01, 8'h02, 8'h03, 8'h04};
    gaps  = '{0, 0, 0, 0};
    drive_txn(beats, gaps, -1, 8'h00, 1'b0);
    n_total++; if (o_rv_cnt != 1) $display("FAIL basic_rv_count: got %0d exp 1", o_rv_cnt); else n_pass++;
    n_total++; if (o_rv_cyc != 5) $display("FAIL basic_latency: got %0d exp 5", o_rv_cyc); else n_pass++;
    n_total++; if (o_start != 4) $display("FAIL basic_start_cycles: got %0d exp 4", o_start); else n_pass++;
    n_total++; if (a_sum !== 16'h000A) $display("FAIL basic_sum: got %h exp 000a", a_sum); else n_pass++;
    n_total++; if (a_cnt !== 8'd4) $display("FAIL basic_cnt: got %0d exp 4", a_cnt); else n_pass++;
    n_total++; if (a_busy !== 1'b0 || a_mode !== done) $display("FAIL basic_idle: busy %b mode %0d exp 0 %0d", a_busy, a_mode, done); else n_pass++;
  endtask

  task automatic test_gap();
    logic [7:0] beats[4];
    int gaps[4];
    beats = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    gaps  = '{0, 3, 0, 0};
    drive_txn(beats, gaps, -1, 8'h00, 1'b0);
    n_total++; if (o_rv_cyc != 8) $display("FAIL gap_latency: got %0d exp 8", o_rv_cyc); else n_pass++;
    n_total++; if (o_rv_cnt != 1) $display("FAIL gap_rv_count: got %0d exp 1", o_rv_cnt); else n_pass++;
    n_total++; if (a_sum !== 16'h03FC) $display("FAIL gap_sum: got %h exp 03fc", a_sum); else n_pass++;
    n_total++; if (a_cnt !== 8'd4) $display("FAIL gap_cnt: got %0d exp 4", a_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] beats[4];
    int gaps[4];
    beats = '{8'h10, 8'h20, 8'h00, 8'h00};
    gaps  = '{0, 0, 0, 0};
    drive_txn(beats, gaps, 2, 8'h30, 1'b0);
    n_total++; if (o_rv_cnt != 0) $display("FAIL abort_rv: got %0d exp 0", o_rv_cnt); else n_pass++;
    n_total++; if (a_sum !== 16'h0030) $display("FAIL abort_sum: got %h exp 0030", a_sum); else n_pass++;
    n_total++; if (a_cnt !== 8'd2) $display("FAIL abort_cnt: got %0d exp 2", a_cnt); else n_pass++;
    n_total++; if (a_mode !== done || a_busy !== 1'b0) $display("FAIL abort_idle: mode %0d busy %b exp %0d 0", a_mode, a_busy, done); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] beats[4];
    int gaps[4];
    int abort_idx, n_acc, exp_sum, exp_cyc;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 4; i++) begin
        beats[i] = 8'($urandom);
        gaps[i]  = int'($urandom_range(0, 2));
      end
      abort_idx = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, 3));
      n_acc = (abort_idx < 0) ? 4 : abort_idx;
      exp_sum = 0;
      for (int i = 0; i < n_acc; i++) exp_sum += int'(beats[i]);
      exp_cyc = 5;
      for (int i = 0; i < 3; i++) exp_cyc += gaps[i];
      drive_txn(beats, gaps, abort_idx, 8'($urandom), 1'b1);
      n_total++; if (a_sum !== 16'(exp_sum)) $display("FAIL rand_sum[%0d]: got %h exp %h", it, a_sum, 16'(exp_sum)); else n_pass++;
      n_total++; if (a_cnt !== 8'(n_acc)) $display("FAIL rand_cnt[%0d]: got %0d exp %0d", it, a_cnt, n_acc); else n_pass++;
      n_total++; if (o_rv_cnt != ((abort_idx < 0) ? 1 : 0)) $display("FAIL rand_rv[%0d]: got %0d exp %0d", it, o_rv_cnt, (abort_idx < 0) ? 1 : 0); else n_pass++;
      if (abort_idx < 0) begin
        n_total++; if (o_rv_cyc != exp_cyc) $display("FAIL rand_latency[%0d]: got %0d exp %0d", it, o_rv_cyc, exp_cyc); else n_pass++;
      end
      n_total++; if (a_busy !== 1'b0) $display("FAIL rand_busy[%0d]: got %b exp 0", it, a_busy); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] beats[4];
    int gaps[4];
    a_go = 1'b1; tick(); a_go = 1'b0;
    a_vld = 1'b1; a_din = 8'h05; tick();
    a_din = 8'h06; tick();
    n_total++; if (a_sum !== 16'h000B || a_cnt !== 8'd2) $display("FAIL rstmid_pre: sum %h cnt %0d exp 000b 2", a_sum, a_cnt); else n_pass++;
    rst = 1'b1; a_go = 1'b1; a_vld = 1'b1; a_din = 8'h07;
    tick();
    n_total++; if (a_sum !== 16'h0 || a_cnt !== 8'd0) $display("FAIL rstmid_clear: sum %h cnt %0d exp 0000 0", a_sum, a_cnt); else n_pass++;
    n_total++; if (a_mode !== done || a_busy !== 1'b0 || a_rv !== 1'b0) $display("FAIL rstmid_idle: mode %0d busy %b rv %b exp %0d 0 0", a_mode, a_busy, a_rv, done); else n_pass++;
    rst = 1'b0; a_go = 1'b0; a_vld = 1'b0;
    beats = '{8'h04, 8'h03, 8'h02, 8'h01};
    gaps  = '{0, 0, 0, 0};
    drive_txn(beats, gaps, -1, 8'h00, 1'b0);
    n_total++; if (o_rv_cyc != 5 || a_sum !== 16'h000A || a_cnt !== 8'd4) $display("FAIL rstmid_after: rv_cyc %0d sum %h cnt %0d exp 5 000a 4", o_rv_cyc, a_sum, a_cnt); else n_pass++;
  endtask

  task automatic test_len255();
    int rv_cnt, rv_cyc;
    rv_cnt = 0; rv_cyc = -1;
    b_go = 1'b1; tick(); b_go = 1'b0;
    b_vld = 1'b1; b_din = 8'hFF;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (b_rv) begin rv_cnt++; rv_cyc = i; end
    end
    b_vld = 1'b0;
    n_total++; if (rv_cnt != 1 || rv_cyc != 255) $display("FAIL len255_rv: count %0d at %0d exp 1 at 255", rv_cnt, rv_cyc); else n_pass++;
    n_total++; if (b_sum !== 16'hFE01) $display("FAIL len255_sum: got %h exp fe01", b_sum); else n_pass++;
    n_total++; if (b_cnt !== 8'd255) $display("FAIL len255_cnt: got %0d exp 255", b_cnt); else n_pass++;
    tick();
    n_total++; if (b_busy !== 1'b0 || b_rv !== 1'b0) $display("FAIL len255_idle: busy %b rv %b exp 0 0", b_busy, b_rv); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int last_rv, pulses;
    logic [7:0] din_cur;
    last_rv = -1; pulses = 0;
    c_go = 1'b1; c_vld = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      din_cur = 8'($urandom);
      c_din = din_cur;
      tick();
      if (c_rv) begin
        pulses++;
        n_total++; if (c_sum !== 16'(din_cur) || c_cnt !== 8'd1) $display("FAIL b2b_result: sum %h cnt %0d exp %h 1", c_sum, c_cnt, 16'(din_cur)); else n_pass++;
        if (last_rv >= 0) begin
          n_total++; if (cyc - last_rv != 3) $display("FAIL b2b_spacing: got %0d exp 3", cyc - last_rv); else n_pass++;
        end
        last_rv = cyc;
      end
    end
    c_go = 1'b0; c_vld = 1'b0;
    n_total++; if (pulses != 10) $display("FAIL b2b_pulses: got %0d exp 10", pulses); else n_pass++;
    tick(); tick();
    n_total++; if (c_busy !== 1'b0) $display("FAIL b2b_idle: busy %b exp 0", c_busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_abort();
    test_random();
    test_reset_mid();
    test_len255();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
